gfx_pixel_serializer: RTL

Parametrised sprite-graphics pixel serializer: the next generation of the ZMC2-style plane-to-pixel converter. It accepts bitplane words from the C-ROM path on a LOAD strobe and holds one word in a pending buffer while the previous word is still shifting. It shifts out NCH pixels per pixel-clock enable, with horizontal flip. When no data is pending it emits explicit transparency and reports underrun/overrun. It sits between the C-ROM data bus and the B1 line-buffer writer.

---
 rtl/gfx_pixel_serializer_if.sv | 41 ++++
 rtl/gfx_pixel_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/gfx_pixel_serializer_if.sv
// Bus bundle for gfx_pixel_serializer: word load side (CLK_EN/LOAD/H/CR) and pixel output side.
// HALF_SEL and the double-width CR exist only when GFXSER_HALFSEL_EN is defined.
interface gfx_pixel_serializer_if #(
    parameter int BPP      = 4,
    parameter int WORD_PIX = 8,
    parameter int NCH      = 2
);
    localparam int STEPS = WORD_PIX / NCH;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
`ifdef GFXSER_HALFSEL_EN
    localparam int DW    = 2 * BPP * WORD_PIX;
`else
    localparam int DW    = BPP * WORD_PIX;
`endif

    logic                 CLK_EN;
    logic                 LOAD;
    logic                 H;
`ifdef GFXSER_HALFSEL_EN
    logic                 HALF_SEL;
`endif
    logic [DW-1:0]        CR;
    logic [NCH*BPP-1:0]   GD;
    logic [NCH-1:0]       DOT;
    logic                 BUSY;
    logic [SW-1:0]        STEP;
    logic                 UNDERRUN;
    logic                 OVERRUN;

`ifdef GFXSER_HALFSEL_EN
    modport master (output CLK_EN, LOAD, H, HALF_SEL, CR,
                    input  GD, DOT, BUSY, STEP, UNDERRUN, OVERRUN);
    modport slave  (input  CLK_EN, LOAD, H, HALF_SEL, CR,
                    output GD, DOT, BUSY, STEP, UNDERRUN, OVERRUN);
`else
    modport master (output CLK_EN, LOAD, H, CR,
                    input  GD, DOT, BUSY, STEP, UNDERRUN, OVERRUN);
    modport slave  (input  CLK_EN, LOAD, H, CR,
                    output GD, DOT, BUSY, STEP, UNDERRUN, OVERRUN);
`endif
endinterface

// File: rtl/gfx_pixel_serializer.sv
// Bitplane-to-pixel serializer with one-word pending buffer, H flip and underrun/overrun pulses.
// Optional GFXSER_HALFSEL_EN: CR is [upper | lower], HALF_SEL latched at load picks the half.
//   state   | meaning
//   S_IDLE  | no active word, outputs forced to zero
//   S_SHIFT | active word emitting NCH pixels per enable, STEP = current step
module gfx_pixel_serializer #(
    parameter int BPP      = 4,
    parameter int WORD_PIX = 8,
    parameter int NCH      = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    gfx_pixel_serializer_if.slave  bus
);
    localparam int STEPS = WORD_PIX / NCH;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int WW    = BPP * WORD_PIX;
    localparam logic [0:0]    S_IDLE    = 1'b0;
    localparam logic [0:0]    S_SHIFT   = 1'b1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    generate
        if (WORD_PIX % NCH != 0) begin : g_bad_nch
            $error("gfx_pixel_serializer: WORD_PIX must be a multiple of NCH");
        end
    endgenerate

    logic [0:0]         state, nxt_state;
    logic               pend_valid, nxt_pend_valid;
    logic [WW-1:0]      pend_word, nxt_pend_word;
    logic               pend_h, nxt_pend_h;
    logic [WW-1:0]      act_word, nxt_act_word;
    logic               act_h, nxt_act_h;
    logic [SW-1:0]      step_cnt, nxt_step;
    logic               transfer, underrun_n, overrun_n;
    logic [WW-1:0]      load_word;
    logic [BPP-1:0]     pix [WORD_PIX];
    logic [NCH*BPP-1:0] gd_n;
    logic [NCH-1:0]     dot_n;

`ifdef GFXSER_HALFSEL_EN
    assign load_word = bus.HALF_SEL ? bus.CR[2*WW-1:WW] : bus.CR[WW-1:0];
`else
    assign load_word = bus.CR;
`endif

    always_comb begin
        nxt_state      = state;
        nxt_pend_valid = pend_valid;
        nxt_pend_word  = pend_word;
        nxt_pend_h     = pend_h;
        nxt_act_word   = act_word;
        nxt_act_h      = act_h;
        nxt_step       = step_cnt;
        transfer       = 1'b0;
        underrun_n     = 1'b0;
        overrun_n      = 1'b0;

        if (state == S_IDLE) begin
            transfer = pend_valid;
        end else if (step_cnt == LAST_STEP) begin
            if (pend_valid) begin
                transfer = 1'b1;
            end else begin
                nxt_state  = S_IDLE;
                nxt_step   = '0;
                underrun_n = 1'b1;
            end
        end else begin
            nxt_step = step_cnt + SW'(1);
        end

        if (transfer) begin
            nxt_state      = S_SHIFT;
            nxt_act_word   = pend_word;
            nxt_act_h      = pend_h;
            nxt_step       = '0;
            nxt_pend_valid = 1'b0;
        end

        // A load on a transfer enable refills the just-emptied slot, so only a non-transfer load overruns.
        if (bus.LOAD) begin
            overrun_n      = pend_valid && !transfer;
            nxt_pend_word  = load_word;
            nxt_pend_h     = bus.H;
            nxt_pend_valid = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < WORD_PIX; i++) begin
            for (int p = 0; p < BPP; p++) begin
                pix[i][p] = nxt_act_word[p*WORD_PIX + i];
            end
        end
    end

    always_comb begin
        gd_n  = '0;
        dot_n = '0;
        if (nxt_state == S_SHIFT) begin
            for (int s = 0; s < STEPS; s++) begin
                if (nxt_step == SW'(s)) begin
                    for (int c = 0; c < NCH; c++) begin
                        gd_n[c*BPP +: BPP] = nxt_act_h ? pix[WORD_PIX-1-(s*NCH+c)] : pix[s*NCH+c];
                    end
                end
            end
            for (int c = 0; c < NCH; c++) begin
                dot_n[c] = |gd_n[c*BPP +: BPP];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            pend_valid   <= 1'b0;
            pend_word    <= '0;
            pend_h       <= 1'b0;
            act_word     <= '0;
            act_h        <= 1'b0;
            step_cnt     <= '0;
            bus.GD       <= '0;
            bus.DOT      <= '0;
            bus.BUSY     <= 1'b0;
            bus.STEP     <= '0;
            bus.UNDERRUN <= 1'b0;
            bus.OVERRUN  <= 1'b0;
        end else if (bus.CLK_EN) begin
            state        <= nxt_state;
            pend_valid   <= nxt_pend_valid;
            pend_word    <= nxt_pend_word;
            pend_h       <= nxt_pend_h;
            act_word     <= nxt_act_word;
            act_h        <= nxt_act_h;
            step_cnt     <= nxt_step;
            bus.GD       <= gd_n;
            bus.DOT      <= dot_n;
            bus.BUSY     <= (nxt_state == S_SHIFT);
            bus.STEP     <= nxt_step;
            bus.UNDERRUN <= underrun_n;
            bus.OVERRUN  <= overrun_n;
        end
    end
endmodule
